seg_bcd_counter: RTL
====================

SEG_BCD_COUNTER -- requirements
Module: seg_bcd_counter

Interface
REQ-001 The block SHALL have parameter DIGITS, default 2, meaning the number of BCD digits/displays (1..4).
REQ-002 The block SHALL have parameter COUNT_MAX, default 99, meaning the top count value (1..10^DIGITS-1), decimal.
REQ-003 The block SHALL have parameter REPEAT_DELAY, default 12500000, meaning hold cycles before auto-repeat starts (>=2).
REQ-004 The block SHALL have parameter REPEAT_RATE, default 2500000, meaning cycles between auto-repeat steps (>=2).
REQ-005 The block SHALL have ports i_Clk, input, 1, meaning the single clock; one clock; all state on its rising edge.
REQ-006 The block SHALL have port i_Reset, input, 1, meaning reset; asynchronous, active-high.
REQ-007 The block SHALL have ports i_Inc / i_Dec, input, 1 each, meaning debounced level switches (1 = pressed).
REQ-008 The block SHALL have port i_Clear, input, 1, meaning debounced level; count to 0 on press edge.
REQ-009 The block SHALL have port i_Freeze, input, 1, meaning level; while 1, count and display hold.
REQ-010 The block SHALL have port o_Count, output, 4*DIGITS, meaning registered BCD count; digit 0 in [3:0].
REQ-011 The block SHALL have port o_Segments, output, 7*DIGITS, meaning active-low segments (0 = lit); per digit bit6=A..bit0=G; digit 0 in [6:0].
REQ-012 The block SHALL have port o_Wrap, output, 1, meaning a one-cycle pulse on any wrap (up or down).

Function
REQ-013 The block SHALL register i_Inc, i_Dec and i_Clear once and SHALL detect press as a 0->1 transition of the registered value.
REQ-014 On a press edge of exactly one of Inc/Dec, the block SHALL step the count by one in the cycle after the edge.
REQ-015 Auto-repeat FSM states SHALL be IDLE, DELAY and REPEAT: IDLE->DELAY on step press; DELAY->REPEAT after REPEAT_DELAY cycles held (one step issued); REPEAT issues one step every REPEAT_RATE cycles; any state->IDLE on release.
REQ-016 If Inc and Dec are both pressed (levels), the block SHALL produce no step and SHALL return the FSM to IDLE.
REQ-017 A Clear press edge SHALL load 0, return the FSM to IDLE, and take priority over any step in the same cycle.
REQ-018 The count SHALL be stored as BCD with per-digit carry/borrow; no binary-to-BCD conversion.
REQ-019 Incrementing at COUNT_MAX SHALL give 0 and pulse o_Wrap; decrementing at 0 SHALL give COUNT_MAX and pulse o_Wrap.
REQ-020 While i_Freeze=1, steps and Clear SHALL be ignored (the FSM holds IDLE), and o_Count and o_Segments SHALL hold.
REQ-021 o_Segments SHALL update one cycle after o_Count (registered encoder output).
REQ-022 Digit values 0-9 SHALL use standard glyphs; values A-F are unreachable and SHALL show all segments off.

Reset
REQ-023 On i_Reset assertion, the block SHALL asynchronously set o_Count=0, o_Wrap=0, FSM=IDLE, all edge registers=0, and o_Segments=7'b0000001 per digit ("0").
REQ-024 Reset during DELAY/REPEAT SHALL abort the repeat; after release, a held switch SHALL NOT step until it is released and pressed again.

Configuration
REQ-025 With SEG_LEADING_ZERO_BLANK_EN defined, leading zero digits above digit 0 SHALL be blanked (7'b1111111), and digit 0 SHALL always be shown.
REQ-026 Without SEG_LEADING_ZERO_BLANK_EN, all digits SHALL always be shown, including leading zeros.

Structure
REQ-027 Package seg_pkg SHALL hold the FSM state typedef, the 7-bit glyph constants for 0-9, and the SEG_BLANK constant.
REQ-028 Sub-module seg_digit_encoder (4-bit BCD to 7-bit active-low, combinational) SHALL be instantiated once per digit.
REQ-029 Timer width SHALL be $clog2 of the max of REPEAT_DELAY and REPEAT_RATE.

Verification (DIGITS=2, COUNT_MAX=99, REPEAT_DELAY=8, REPEAT_RATE=4)
REQ-030 Reset, then 3 short Inc presses -> o_Count=8'h03; o_Segments[6:0]=0000110 one cycle after o_Count.
REQ-031 Count 99, Inc press -> o_Count=8'h00, one-cycle o_Wrap; count 00, Dec press -> o_Count=8'h99, o_Wrap pulse.
REQ-032 Hold Inc for 30 cycles from 00 -> steps 1 (edge) +1 at cycle 8 +1 every 4 cycles thereafter; release -> IDLE.
REQ-033 Inc and Dec pressed in the same cycle -> no change; Clear and Inc edge in the same cycle -> o_Count=8'h00.
REQ-034 Freeze=1, 5 Inc presses -> o_Count unchanged; Freeze=0 -> next press counts.
REQ-035 Reset mid-REPEAT with Inc still held -> count 00, no step until re-press; with SEG_LEADING_ZERO_BLANK_EN, count 07 -> digit 1 = 1111111.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared FSM state type, seven-segment glyphs and a constant BCD helper
// for the seg_bcd_counter block.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } state_t;

  // Active-low glyphs, bit6 = A .. bit0 = G
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Elaboration-time only: turns the decimal top value into a BCD constant.
  function automatic logic [15:0] bcd_of(input int v);
    logic [15:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg_digit_encoder.sv
// One BCD digit to an active-low seven-segment pattern.
// Non-decimal codes show nothing.
module seg_digit_encoder
  import seg_pkg::*;
(
  input  logic [3:0] i_Bcd,
  output logic [6:0] o_Seg
);

  always_comb begin
    unique case (i_Bcd)
      4'd0:    o_Seg = SEG_0;
      4'd1:    o_Seg = SEG_1;
      4'd2:    o_Seg = SEG_2;
      4'd3:    o_Seg = SEG_3;
      4'd4:    o_Seg = SEG_4;
      4'd5:    o_Seg = SEG_5;
      4'd6:    o_Seg = SEG_6;
      4'd7:    o_Seg = SEG_7;
      4'd8:    o_Seg = SEG_8;
      4'd9:    o_Seg = SEG_9;
      default: o_Seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_bcd_counter.sv
// Up/down BCD counter with press auto-repeat and registered 7-seg output.
// Define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg_bcd_counter
  import seg_pkg::*;
#(
  parameter int DIGITS       = 2,
  parameter int COUNT_MAX    = 99,
  parameter int REPEAT_DELAY = 12500000,
  parameter int REPEAT_RATE  = 2500000
) (
  input  logic                  i_Clk,
  input  logic                  i_Reset,
  input  logic                  i_Inc,
  input  logic                  i_Dec,
  input  logic                  i_Clear,
  input  logic                  i_Freeze,
  output logic [4*DIGITS-1:0]   o_Count,
  output logic [7*DIGITS-1:0]   o_Segments,
  output logic                  o_Wrap
);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                        REPEAT_DELAY : REPEAT_RATE;
  localparam int TW = $clog2(TMAX);
  localparam int CW = 4 * DIGITS;
  localparam logic [CW-1:0] MAX_BCD = CW'(bcd_of(COUNT_MAX));
  localparam logic [TW-1:0] DLY_END = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RPT_END = TW'(REPEAT_RATE - 1);

  logic                r_Valid;
  logic [2:0]          r_InQ;
  logic [2:0]          r_InP;
  logic [2:0]          r_Arm;
  state_t              r_State;
  logic                r_Dir;
  logic [TW-1:0]       r_Timer;
  logic [CW-1:0]       r_Count;
  logic                r_Wrap;
  logic [7*DIGITS-1:0] r_Seg;

  logic [2:0]          w_Edge;
  logic                w_Both;
  logic                w_Held;
  logic                w_Dn;
  logic                w_Cy;
  logic [CW-1:0]       w_Next;
  logic                w_NextWrap;
  logic [TW-1:0]       w_End;
  logic [7*DIGITS-1:0] w_Enc;
  logic [7*DIGITS-1:0] w_Seg;

  // Bits: 0 = Inc, 1 = Dec, 2 = Clear. A switch must be seen released
  // after reset before its press counts, so a held key cannot step.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_Valid <= 1'b0;
      r_InQ   <= '0;
      r_InP   <= '0;
      r_Arm   <= '0;
    end else begin
      r_Valid <= 1'b1;
      r_InQ   <= {i_Clear, i_Dec, i_Inc};
      r_InP   <= r_InQ;
      r_Arm   <= r_Arm | ({3{r_Valid}} & ~r_InQ);
    end
  end

  assign w_Edge = r_InQ & ~r_InP & r_Arm;
  assign w_Both = r_InQ[0] & r_InQ[1];
  assign w_Held = r_Dir ? r_InQ[1] : r_InQ[0];
  assign w_End  = (r_State == ST_DELAY) ? DLY_END : RPT_END;

  always_comb begin
    w_Dn       = (|w_Edge[1:0]) ? w_Edge[1] : r_Dir;
    w_Next     = r_Count;
    w_NextWrap = 1'b0;
    w_Cy       = 1'b1;
    if (!w_Dn) begin
      if (r_Count == MAX_BCD) begin
        w_Next     = '0;
        w_NextWrap = 1'b1;
      end else begin
        for (int d = 0; d < DIGITS; d++) begin
          if (w_Cy) begin
            if (r_Count[4*d +: 4] == 4'd9) begin
              w_Next[4*d +: 4] = 4'd0;
            end else begin
              w_Next[4*d +: 4] = r_Count[4*d +: 4] + 4'd1;
              w_Cy = 1'b0;
            end
          end
        end
      end
    end else begin
      if (r_Count == '0) begin
        w_Next     = MAX_BCD;
        w_NextWrap = 1'b1;
      end else begin
        for (int d = 0; d < DIGITS; d++) begin
          if (w_Cy) begin
            if (r_Count[4*d +: 4] == 4'd0) begin
              w_Next[4*d +: 4] = 4'd9;
            end else begin
              w_Next[4*d +: 4] = r_Count[4*d +: 4] - 4'd1;
              w_Cy = 1'b0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_State <= ST_IDLE;
      r_Dir   <= 1'b0;
      r_Timer <= '0;
      r_Count <= '0;
      r_Wrap  <= 1'b0;
    end else begin
      r_Wrap <= 1'b0;
      if (i_Freeze) begin
        r_State <= ST_IDLE;
      end else if (w_Edge[2]) begin
        r_Count <= '0;
        r_State <= ST_IDLE;
      end else if (w_Both) begin
        r_State <= ST_IDLE;
      end else if (|w_Edge[1:0]) begin
        r_Count <= w_Next;
        r_Wrap  <= w_NextWrap;
        r_Dir   <= w_Edge[1];
        r_State <= ST_DELAY;
        r_Timer <= '0;
      end else begin
        unique case (r_State)
          ST_DELAY, ST_REPEAT: begin
            if (!w_Held) begin
              r_State <= ST_IDLE;
            end else if (r_Timer == w_End) begin
              r_Count <= w_Next;
              r_Wrap  <= w_NextWrap;
              r_State <= ST_REPEAT;
              r_Timer <= '0;
            end else begin
              r_Timer <= r_Timer + 1'b1;
            end
          end
          default: r_State <= ST_IDLE;
        endcase
      end
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    seg_digit_encoder u_enc (
      .i_Bcd (r_Count[4*g +: 4]),
      .o_Seg (w_Enc[7*g +: 7])
    );
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic w_Lead;
  always_comb begin
    w_Seg  = w_Enc;
    w_Lead = 1'b1;
    for (int d = DIGITS - 1; d > 0; d--) begin
      w_Lead = w_Lead & (r_Count[4*d +: 4] == 4'd0);
      if (w_Lead) w_Seg[7*d +: 7] = SEG_BLANK;
    end
  end
`else
  assign w_Seg = w_Enc;
`endif

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) r_Seg <= {DIGITS{SEG_0}};
    else         r_Seg <= w_Seg;
  end

  assign o_Count    = r_Count;
  assign o_Segments = r_Seg;
  assign o_Wrap     = r_Wrap;

endmodule
